// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a single sign-fix-up cycle.
//
// state | meaning
// IDLE  | waiting for a legal start
// ITER  | BITS magnitude iterations, one bit per cycle
// FIX   | apply result signs, register RZVal and div_by_zero
// DONE  | result valid for one cycle; a legal start here goes straight to ITER
module mul_div_unit #(
  parameter int BITS = 32,
  parameter int CNTW = $clog2(BITS) + 1
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                start,
  input  logic                MUL,
  input  logic                DIV,
  input  logic                signed_mode,
  input  logic [BITS-1:0]     A,
  input  logic [BITS-1:0]     B,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [2*BITS-1:0]   RZVal
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t state, state_nx;

  logic              accept;
  logic              op_div;
  logic              neg_lo;
  logic              neg_hi;
  logic              dz;
  logic [CNTW-1:0]   cnt;
  logic [BITS-1:0]   opnd;
  logic [2*BITS-1:0] acc;
  logic [BITS-1:0]   mag_a;
  logic [BITS-1:0]   mag_b;
  logic [BITS:0]     mul_sum;
  logic [2*BITS-1:0] mul_next;
  logic [BITS:0]     div_shift;
  logic [BITS:0]     div_diff;
  logic              div_ok;
  logic [2*BITS-1:0] div_next;
  logic [2*BITS-1:0] fix_val;

  assign accept = start && (MUL ^ DIV) && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_ITER;
      S_ITER: if (cnt == CNTW'(BITS - 1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = accept ? S_ITER : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_ITER) || (state == S_FIX);
    done = (state == S_DONE);
  end

  always_comb begin
    mag_a = (signed_mode && A[BITS-1]) ? (~A + 1'b1) : A;
    mag_b = (signed_mode && B[BITS-1]) ? (~B + 1'b1) : B;
  end

  // acc holds {hi, multiplier} for MUL and {remainder, dividend} for DIV;
  // both shift right/left by one bit per iteration.
  always_comb begin
    mul_sum   = {1'b0, acc[2*BITS-1:BITS]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[BITS-1:1]};
    div_shift = acc[2*BITS-1:BITS-1];
    div_diff  = div_shift - {1'b0, opnd};
    div_ok    = !div_diff[BITS];
    div_next  = {(div_ok ? div_diff[BITS-1:0] : div_shift[BITS-1:0]),
                 acc[BITS-2:0], div_ok};
  end

  // Divide by zero naturally leaves |A| in the remainder, so only LO needs forcing.
  always_comb begin
    fix_val = acc;
    if (!op_div) begin
      if (neg_lo) fix_val = ~acc + 1'b1;
    end else begin
      fix_val[BITS-1:0] = dz ? '1 :
                          (neg_lo ? (~acc[BITS-1:0] + 1'b1) : acc[BITS-1:0]);
      fix_val[2*BITS-1:BITS] = neg_hi ? (~acc[2*BITS-1:BITS] + 1'b1)
                                      : acc[2*BITS-1:BITS];
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      op_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
      opnd        <= '0;
      acc         <= '0;
      RZVal       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        op_div <= DIV;
        opnd   <= DIV ? mag_b : mag_a;
        acc    <= {{BITS{1'b0}}, (DIV ? mag_a : mag_b)};
        neg_lo <= signed_mode && (A[BITS-1] ^ B[BITS-1]);
        neg_hi <= signed_mode && DIV && A[BITS-1];
        dz     <= DIV && (B == '0);
        cnt    <= '0;
      end else if (state == S_ITER) begin
        acc <= op_div ? div_next : mul_next;
        cnt <= cnt + 1'b1;
      end
      if (state == S_FIX) begin
        RZVal       <= fix_val;
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit at BITS=8 and BITS=32: directed and random operations
// compared against an arithmetic reference model, plus latency and reset checks.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st8, mu8, dv8, sm8, bz8, dn8, dz8;
  logic [7:0]  a8, b8;
  logic [15:0] rz8;
  logic        st32, mu32, dv32, sm32, bz32, dn32, dz32;
  logic [31:0] a32, b32;
  logic [63:0] rz32;

  mul_div_unit #(.BITS(8)) u8 (
    .Clock(clk), .reset(rst), .start(st8), .MUL(mu8), .DIV(dv8),
    .signed_mode(sm8), .A(a8), .B(b8), .busy(bz8), .done(dn8),
    .div_by_zero(dz8), .RZVal(rz8)
  );

  mul_div_unit #(.BITS(32)) u32 (
    .Clock(clk), .reset(rst), .start(st32), .MUL(mu32), .DIV(dv32),
    .signed_mode(sm32), .A(a32), .B(b32), .busy(bz32), .done(dn32),
    .div_by_zero(dz32), .RZVal(rz32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, mu, dv, sm, input logic [31:0] a, b);
    if (w == 8) begin
      st8 = st; mu8 = mu; dv8 = dv; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      st32 = st; mu32 = mu; dv32 = dv; sm32 = sm; a32 = a; b32 = b;
    end
  endtask

  function automatic logic [63:0] rz_of(input int w);
    return (w == 8) ? {48'b0, rz8} : rz32;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 8) ? bz8 : bz32;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 8) ? dn8 : dn32;
  endfunction
  function automatic logic dz_of(input int w);
    return (w == 8) ? dz8 : dz32;
  endfunction

  // Plain integer arithmetic: SV '/' truncates toward zero and '%' takes the dividend's sign.
  function automatic void model(input int w, input logic mu, sm, input logic [31:0] a, b,
                                output logic [63:0] rz, output logic dz);
    longint full, half, mask, av, bv, p, q, r;
    full = 64'sd1 << w;
    half = full >>> 1;
    mask = full - 1;
    av = a & mask;
    bv = b & mask;
    dz = 1'b0;
    if (sm) begin
      if (av >= half) av -= full;
      if (bv >= half) bv -= full;
    end
    if (mu) begin
      p  = av * bv;
      rz = (w == 32) ? p : (p & 64'hFFFF);
    end else if (bv == 0) begin
      rz = ((a & mask) << w) | mask;
      dz = 1'b1;
    end else begin
      q  = av / bv;
      r  = av % bv;
      rz = ((r & mask) << w) | (q & mask);
    end
  endfunction

  // Issues one legal op and returns in the cycle where done is high.
  task automatic run_op(input int w, input logic mu, sm, input logic [31:0] a, b,
                        input string tag, input bit poke);
    logic [63:0] erz, prev;
    logic        edz;
    int          n;
    model(w, mu, sm, a, b, erz, edz);
    prev = rz_of(w);
    drive(w, 1'b1, mu, !mu, sm, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
    chk($sformatf("w%0d %s busy", w, tag), 64'(busy_of(w)), 64'd1);
    n = 0;
    while (n < w + 6) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 2) drive(w, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5A, 32'h3);
      if (poke && n == 3) drive(w, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (n == w) chk($sformatf("w%0d %s hold", w, tag), rz_of(w), prev);
      if (done_of(w)) break;
    end
    // done is captured by the edge after the one where it is first seen high
    chk($sformatf("w%0d %s latency", w, tag), 64'(n + 1), 64'(w + 2));
    chk($sformatf("w%0d %s rz", w, tag), rz_of(w), erz);
    chk($sformatf("w%0d %s dz", w, tag), 64'(dz_of(w)), 64'(edz));
  endtask

  task automatic idle_step(input int w);
    @(posedge clk); #1;
    chk($sformatf("w%0d idle done", w), 64'(done_of(w)), 64'd0);
    chk($sformatf("w%0d idle busy", w), 64'(busy_of(w)), 64'd0);
  endtask

  task automatic check_cleared(input int w, input string tag);
    chk($sformatf("w%0d %s busy0", w, tag), 64'(busy_of(w)), 64'd0);
    chk($sformatf("w%0d %s done0", w, tag), 64'(done_of(w)), 64'd0);
    chk($sformatf("w%0d %s dz0", w, tag), 64'(dz_of(w)), 64'd0);
    chk($sformatf("w%0d %s rz0", w, tag), rz_of(w), 64'd0);
  endtask

  task automatic run_width(input int w);
    logic [31:0] mask, half;
    logic        mu, sm;
    logic [31:0] a, b;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    half = (w == 32) ? 32'h8000_0000 : 32'h0000_0080;

    run_op(w, 1'b1, 1'b0, mask, mask, "umul_ones", 1'b0);
    idle_step(w);
    run_op(w, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd3, "smul_m7x3", 1'b0);
    idle_step(w);
    run_op(w, 1'b1, 1'b0, 32'h22, 32'h10, "umul_22x10", 1'b0);
    idle_step(w);
    run_op(w, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv_m7d2", 1'b0);
    idle_step(w);
    run_op(w, 1'b0, 1'b0, 32'd100, 32'd7, "udiv_100d7", 1'b0);
    idle_step(w);
    run_op(w, 1'b0, 1'b0, 32'h22, 32'd0, "div0", 1'b0);
    run_op(w, 1'b0, 1'b1, half, mask, "sdiv_ovf_b2b", 1'b0);
    idle_step(w);
    run_op(w, 1'b1, 1'b0, 32'h0123_4567, 32'h89, "poke", 1'b1);
    idle_step(w);

    drive(w, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5, 32'h3);
    @(posedge clk); #1;
    chk($sformatf("w%0d both busy", w), 64'(busy_of(w)), 64'd0);
    drive(w, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5, 32'h3);
    @(posedge clk); #1;
    chk($sformatf("w%0d none busy", w), 64'(busy_of(w)), 64'd0);
    drive(w, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_step(w);

    for (int i = 0; i < 15; i++) begin
      mu = 1'($urandom);
      sm = 1'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_op(w, mu, sm, a, b, $sformatf("rnd%0d", i), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_step(w);
    end
    idle_step(w);

    run_op(w, 1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, "pre_rst_div0", 1'b0);
    idle_step(w);
    drive(w, 1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 32'h13);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_cleared(w, "async_rst");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(w, 1'b1, 1'b0, 32'h77, 32'h13, "post_rst", 1'b0);
    idle_step(w);
  endtask

  initial begin
    rst = 1'b1;
    drive(8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(32, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    check_cleared(8, "reset");
    check_cleared(32, "reset");
    rst = 1'b0;
    @(posedge clk); #1;
    run_width(32);
    run_width(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
